cmp_share_arbiter: RTL and testbench

Round-robin scheduler that shares one registered 8-bit magnitude comparator (equal, greater-than and less-than flags) between NREQ requesters. Each requester presents an operand pair and a request. The block grants one requester at a time, captures its operands, performs the comparison and returns the three flags with the winner's index. It sits between the comparator datapath and the client blocks that need occasional compares, replacing per-client comparator instances to save area.

---
 rtl/cmp_share_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_cmp_share_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin share of one registered magnitude comparator.
// Optional build macro CMP_APPROX_EN masks the low APPROX_BITS before comparing.
module cmp_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*W-1:0]        a_flat,
  input  logic [NREQ*W-1:0]        b_flat,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     aeqb,
  output logic                     agtb,
  output logic                     altb
);

  localparam int IDW = $clog2(NREQ);

`ifdef CMP_APPROX_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  localparam int MASK_BITS = APPROX_ON ? APPROX_BITS : 0;
  localparam logic [W-1:0] CMP_MASK = {W{1'b1}} << MASK_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_q, win_d;
  logic [IDW-1:0] done_id_q, done_id_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           aeqb_q, aeqb_d;
  logic           agtb_q, agtb_d;
  logic           altb_q, altb_d;

  logic           req_any;
  logic [IDW-1:0] win_id;
  logic [W-1:0]   a_win;
  logic [W-1:0]   b_win;
  logic [W-1:0]   cmp_a;
  logic [W-1:0]   cmp_b;
  logic [NREQ-1:0] gnt_c;

  // First requester found scanning ptr+1, ptr+2, ... ptr (mod NREQ)
  function automatic logic [IDW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [IDW-1:0]  p
  );
    logic [IDW-1:0] pick;
    logic           hit;
    int             idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!hit && r[idx]) begin
        hit  = 1'b1;
        pick = idx[IDW-1:0];
      end
    end
    return pick;
  endfunction

  // Round-robin winner among current requests
  always_comb begin
    req_any = |req;
    win_id  = rr_pick(req, ptr_q);
  end

  // Operand mux for the winner
  always_comb begin
    a_win = '0;
    b_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == i[IDW-1:0]) begin
        a_win = a_flat[i*W +: W];
        b_win = b_flat[i*W +: W];
      end
    end
  end

  // Captured operands with ignored LSBs cleared
  always_comb begin
    cmp_a = op_a_q & CMP_MASK;
    cmp_b = op_b_q & CMP_MASK;
  end

  // Next-state, capture and result logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    done_id_d = done_id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    aeqb_d    = aeqb_q;
    agtb_d    = agtb_q;
    altb_d    = altb_q;
    gnt_c     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          gnt_c   = {{(NREQ-1){1'b0}}, 1'b1} << win_id;
          ptr_d   = win_id;
          win_d   = win_id;
          op_a_d  = a_win;
          op_b_d  = b_win;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        done_id_d = win_q;
        unique case (1'b1)
          (cmp_a == cmp_b): begin
            aeqb_d = 1'b1;
            agtb_d = 1'b0;
            altb_d = 1'b0;
          end
          (cmp_a > cmp_b): begin
            aeqb_d = 1'b0;
            agtb_d = 1'b1;
            altb_d = 1'b0;
          end
          default: begin
            aeqb_d = 1'b0;
            agtb_d = 1'b0;
            altb_d = 1'b1;
          end
        endcase
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDW'(NREQ - 1);
      win_q     <= '0;
      done_id_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      aeqb_q    <= 1'b0;
      agtb_q    <= 1'b0;
      altb_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      done_id_q <= done_id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      aeqb_q    <= aeqb_d;
      agtb_q    <= agtb_d;
      altb_q    <= altb_d;
    end
  end

  assign gnt     = rst ? '0 : gnt_c;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign done_id = done_id_q;
  assign aeqb    = aeqb_q;
  assign agtb    = agtb_q;
  assign altb    = altb_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed checks of the shared comparator arbiter.
// Flag expectations follow CMP_APPROX_EN when the bench is built with it.
module tb_cmp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_flat;
  logic [31:0] b_flat;
  logic [3:0]  gnt;
  logic        busy;
  logic        done;
  logic [1:0]  done_id;
  logic        aeqb;
  logic        agtb;
  logic        altb;

  int checks = 0;
  int errors = 0;

  cmp_share_arbiter #(.NREQ(4), .W(8), .APPROX_BITS(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_flat(a_flat), .b_flat(b_flat),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .aeqb(aeqb), .agtb(agtb), .altb(altb)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    a_flat[i*8 +: 8] = a;
    b_flat[i*8 +: 8] = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'hF;
    a_flat = 32'h1234_5678;
    b_flat = 32'h8765_4321;
    tick();
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL reset_done_id got %0d want 0", done_id); end
    checks++; if ({aeqb, agtb, altb} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {aeqb, agtb, altb}); end
    tick();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single;
    set_op(0, 8'h5A, 8'h3C);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt got %b want 0001", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got %b want 0", busy); end
    tick();
    req = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_cmp got %b want 0000", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done1 got %b want 0", done); end
    tick();
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done2 got %b want 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy2 got %b want 1", busy); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", done_id); end
    checks++; if ({aeqb, agtb, altb} !== 3'b010) begin errors++; $display("FAIL single_flags got %b want 010", {aeqb, agtb, altb}); end
    tick();
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done3 got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy3 got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    set_op(0, 8'h07, 8'h07);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b2b_gnt0 got %b want 0001", gnt); end
    tick();
    tick();
    #1;
    checks++; if ({done, aeqb, agtb, altb} !== 4'b1100) begin errors++; $display("FAIL b2b_result got %b want 1100", {done, aeqb, agtb, altb}); end
    tick();
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL b2b_regnt got %b want 0001", gnt); end
    tick();
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_contention;
    logic [2:0] ef [4];
    ef = '{3'b001, 3'b100, 3'b010, 3'b010};
    do_reset();
    set_op(0, 8'h10, 8'h20);
    set_op(1, 8'h30, 8'h30);
    set_op(2, 8'h50, 8'h40);
    set_op(3, 8'hFF, 8'h00);
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (gnt !== (4'b0001 << k)) begin errors++; $display("FAIL cont_gnt%0d got %b want %b", k, gnt, 4'b0001 << k); end
      tick();
      req[k] = 1'b0;
      tick();
      #1;
      checks++; if ({done, done_id} !== {1'b1, 2'(k)}) begin errors++; $display("FAIL cont_done%0d got %b/%0d want 1/%0d", k, done, done_id, k); end
      checks++; if ({aeqb, agtb, altb} !== ef[k]) begin errors++; $display("FAIL cont_flags%0d got %b want %b", k, {aeqb, agtb, altb}, ef[k]); end
      tick();
    end
  endtask

  task automatic test_rotation;
    set_op(2, 8'h01, 8'h02);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rot_gnt2 got %b want 0100", gnt); end
    tick();
    set_op(0, 8'h03, 8'h03);
    req = 4'b0101;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rot_busy_gnt got %b want 0000", gnt); end
    tick();
    tick();
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rot_gnt0 got %b want 0001", gnt); end
    tick();
    req = 4'b0100;
    tick();
    #1;
    checks++; if ({done, done_id} !== 3'b100) begin errors++; $display("FAIL rot_done0 got %b/%0d want 1/0", done, done_id); end
    tick();
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rot_gnt2b got %b want 0100", gnt); end
    tick();
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_approx;
    logic [2:0] exp1;
`ifdef CMP_APPROX_EN
    exp1 = 3'b100;
`else
    exp1 = 3'b001;
`endif
    set_op(3, 8'h41, 8'h42);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    #1;
    checks++; if ({done, aeqb, agtb, altb} !== {1'b1, exp1}) begin errors++; $display("FAIL approx_41_42 got %b want %b", {done, aeqb, agtb, altb}, {1'b1, exp1}); end
    tick();
    set_op(3, 8'h80, 8'h7F);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    #1;
    checks++; if ({done, aeqb, agtb, altb} !== 4'b1010) begin errors++; $display("FAIL approx_80_7f got %b want 1010", {done, aeqb, agtb, altb}); end
    tick();
  endtask

  task automatic test_reset_mid;
    set_op(1, 8'h01, 8'h02);
    req = 4'b0010;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rmid_gnt got %b want 0010", gnt); end
    tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({gnt, busy, done} !== 6'b000000) begin errors++; $display("FAIL rmid_ctrl got %b want 000000", {gnt, busy, done}); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL rmid_id got %0d want 0", done_id); end
    checks++; if ({aeqb, agtb, altb} !== 3'b000) begin errors++; $display("FAIL rmid_flags got %b want 000", {aeqb, agtb, altb}); end
    tick();
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_nodone got %b want 0", done); end
    req = 4'hF;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_prio got %b want 0001", gnt); end
    tick();
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_withdraw_opchange;
    set_op(0, 8'h11, 8'h99);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wd_gnt0 got %b want 0001", gnt); end
    tick();
    set_op(0, 8'hFF, 8'h00);
    set_op(1, 8'h22, 8'h22);
    req = 4'b0010;
    tick();
    req = '0;
    #1;
    checks++; if ({done, aeqb, agtb, altb} !== 4'b1001) begin errors++; $display("FAIL opchg_flags got %b want 1001", {done, aeqb, agtb, altb}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      #1;
      checks++; if ({gnt, busy} !== 5'b00000) begin errors++; $display("FAIL wd_idle%0d got %b want 00000", c, {gnt, busy}); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a_flat = '0;
    b_flat = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_contention();
    test_rotation();
    test_approx();
    test_reset_mid();
    test_withdraw_opchange();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
